rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter_if.sv | 27 ++
 rtl/rr_mux_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between four requesters, the round-robin arbiter and the shared output slot.
// "master" is the requester/downstream side; "slave" is the arbiter side.
interface rr_mux_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned N_REQ = 4;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        grant;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic                    out_ready;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, grant, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, grant, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter feeding one registered output slot.
// Define RR_ARB_PACKET_LOCK_EN to hold the grant until a beat with last=1 is transferred.
module rr_mux_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  rr_mux_arbiter_if.slave bus
);
  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;

  logic              slot_free;
  logic [N_REQ-1:0]  ready;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic              win_found;

  // The slot can take a beat when empty or when it drains this cycle.
  assign slot_free = !out_valid_q || bus.out_ready;
  assign ready     = grant_q & {N_REQ{slot_free}};
  assign xfer      = |(ready & bus.req_valid);

  // Data/last of the currently granted requester.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
        sel_last = bus.req_last[i];
      end
    end
  end

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (!win_found && bus.req_valid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state logic for the grant FSM.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_GRANT;
          grant_d  = N_REQ'(1) << win_idx;
          rr_ptr_d = win_idx;
        end
      end
      S_GRANT: begin
        if (xfer) begin
`ifdef RR_ARB_PACKET_LOCK_EN
          if (sel_last) begin
            state_d = S_IDLE;
            grant_d = '0;
          end
`else
          state_d = S_IDLE;
          grant_d = '0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output slot: reload on transfer (no bubble), otherwise drain when accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.grant     = grant_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule
